// File: rtl/vector_cov2_integrator.sv
// 2x2 spatial covariance integrator: per-bin accumulation of r11, r22 and r12 over
// acc_len spectra, then runtime shift and saturation to the eigen-solver format.
module vector_cov2_integrator #(
    parameter int unsigned DIN_WIDTH     = 16,
    parameter int unsigned DIN_POINT     = 14,
    parameter int unsigned VECTOR_LEN    = 64,
    parameter int unsigned ACC_WIDTH     = 48,
    parameter int unsigned ACC_LEN_WIDTH = 16,
    parameter int unsigned SHIFT_WIDTH   = 5,
    parameter int unsigned DOUT_WIDTH    = 16,
    parameter int unsigned DOUT_POINT    = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIN_WIDTH-1:0]          din1_re,
    input  logic [DIN_WIDTH-1:0]          din1_im,
    input  logic [DIN_WIDTH-1:0]          din2_re,
    input  logic [DIN_WIDTH-1:0]          din2_im,
    input  logic                          din_valid,
    input  logic                          sync,
    input  logic [ACC_LEN_WIDTH-1:0]      acc_len,
    input  logic [SHIFT_WIDTH-1:0]        acc_shift,
    output logic [DOUT_WIDTH-1:0]         r11,
    output logic [DOUT_WIDTH-1:0]         r22,
    output logic [DOUT_WIDTH-1:0]         r12_re,
    output logic [DOUT_WIDTH-1:0]         r12_im,
    output logic [$clog2(VECTOR_LEN)-1:0] dout_bin,
    output logic                          dout_valid,
    output logic                          dout_last,
    output logic                          dout_ovf,
    output logic                          sync_err
);
    localparam int unsigned BIN_W     = $clog2(VECTOR_LEN);
    localparam int unsigned PW        = 2 * DIN_WIDTH + 1;
    localparam int unsigned FRAC_DROP = 2 * DIN_POINT - DOUT_POINT;
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(VECTOR_LEN - 1);

    typedef enum logic {StWaitSync, StInteg} state_t;

    function automatic logic signed [ACC_WIDTH-1:0] sat_acc(
        input logic signed [ACC_WIDTH-1:0] a, input logic signed [ACC_WIDTH-1:0] b);
        logic signed [ACC_WIDTH:0] s;
        s = (ACC_WIDTH+1)'(a) + (ACC_WIDTH+1)'(b);
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) sat_acc = {s[ACC_WIDTH], {(ACC_WIDTH-1){~s[ACC_WIDTH]}}};
        else                                sat_acc = s[ACC_WIDTH-1:0];
    endfunction

    // Returns {overflow, saturated value}.
    function automatic logic [DOUT_WIDTH:0] sat_out(input logic signed [ACC_WIDTH-1:0] v);
        logic signed [ACC_WIDTH-1:0] hi, lo;
        hi = ACC_WIDTH'({(DOUT_WIDTH-1){1'b1}});
        lo = ~hi;
        if (v > hi)      sat_out = {2'b10, {(DOUT_WIDTH-1){1'b1}}};
        else if (v < lo) sat_out = {2'b11, {(DOUT_WIDTH-1){1'b0}}};
        else             sat_out = {1'b0, v[DOUT_WIDTH-1:0]};
    endfunction

    state_t                   state_q, state_d;
    logic [BIN_W-1:0]         bin_q, bin_d, smp_bin;
    logic [ACC_LEN_WIDTH-1:0] spec_q, spec_d, smp_spec, acc_len_q, acc_len_d, len_eff;
    logic [SHIFT_WIDTH-1:0]   shift_q, shift_d, smp_shift;
    logic                     accept, restart, start, smp_first, smp_last;
    logic                     sync_err_d, sync_err_q;

    // Sample classification: which bin/spectrum this din_valid belongs to and whether it
    // opens a new integration (where acc_len/acc_shift are latched).
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        spec_d     = spec_q;
        acc_len_d  = acc_len_q;
        shift_d    = shift_q;
        accept     = 1'b0;
        restart    = 1'b0;
        sync_err_d = 1'b0;
        unique case (state_q)
            StWaitSync: begin
                if (din_valid && sync) begin
                    accept  = 1'b1;
                    restart = 1'b1;
                end
            end
            StInteg: begin
                if (din_valid) begin
                    accept = 1'b1;
                    if (sync && bin_q != '0) begin
                        restart    = 1'b1;
                        sync_err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        smp_bin   = restart ? '0 : bin_q;
        smp_spec  = restart ? '0 : spec_q;
        start     = accept && (smp_bin == '0) && (smp_spec == '0);
        len_eff   = acc_len_q;
        smp_shift = shift_q;
        if (start) begin
            len_eff   = (acc_len == '0) ? ACC_LEN_WIDTH'(1) : acc_len;
            smp_shift = acc_shift;
            acc_len_d = len_eff;
            shift_d   = acc_shift;
        end
        smp_first = (smp_spec == '0);
        smp_last  = (smp_spec == len_eff - ACC_LEN_WIDTH'(1));
        if (accept) begin
            state_d = StInteg;
            if (smp_bin == LAST_BIN) begin
                bin_d  = '0;
                spec_d = smp_last ? '0 : smp_spec + ACC_LEN_WIDTH'(1);
            end else begin
                bin_d  = smp_bin + BIN_W'(1);
                spec_d = smp_spec;
            end
        end
    end

    // Control state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StWaitSync;
            bin_q      <= '0;
            spec_q     <= '0;
            acc_len_q  <= '0;
            shift_q    <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            spec_q     <= spec_d;
            acc_len_q  <= acc_len_d;
            shift_q    <= shift_d;
            sync_err_q <= sync_err_d;
        end
    end

    logic signed [PW-1:0] x1r, x1i, x2r, x2i;
    logic signed [PW-1:0] prod [4];
    assign x1r = PW'($signed(din1_re));
    assign x1i = PW'($signed(din1_im));
    assign x2r = PW'($signed(din2_re));
    assign x2i = PW'($signed(din2_im));

    // Full-precision products: r11, r22, Re/Im of x1*conj(x2).
    always_comb begin
        prod[0] = x1r * x1r + x1i * x1i;
        prod[1] = x2r * x2r + x2i * x2i;
        prod[2] = x1r * x2r + x1i * x2i;
        prod[3] = x1i * x2r - x1r * x2i;
    end

    logic                       s1_valid, s1_first, s1_last;
    logic [BIN_W-1:0]           s1_bin;
    logic [SHIFT_WIDTH-1:0]     s1_shift;
    logic signed [PW-1:0]       s1_p [4];
    logic                       s2_valid, s2_first, s2_last;
    logic [BIN_W-1:0]           s2_bin;
    logic [SHIFT_WIDTH-1:0]     s2_shift;
    logic signed [ACC_WIDTH-1:0] s2_p [4];
    logic [4*ACC_WIDTH-1:0]     mem [VECTOR_LEN];
    logic [4*ACC_WIDTH-1:0]     rd_q;
    logic signed [ACC_WIDTH-1:0] wsum [4];
    logic                       s3_valid;
    logic [BIN_W-1:0]           s3_bin;
    logic signed [ACC_WIDTH-1:0] s3_y [4];
    logic [DOUT_WIDTH:0]        so [4];
    int unsigned                sh_amt;

    // Stage 3 arithmetic: first spectrum overwrites, later ones saturate-accumulate.
    always_comb begin
        sh_amt = 32'(s2_shift) + FRAC_DROP;
        for (int k = 0; k < 4; k++) begin
            wsum[k] = s2_first ? s2_p[k]
                               : sat_acc($signed(rd_q[k*ACC_WIDTH +: ACC_WIDTH]), s2_p[k]);
            so[k]   = sat_out(s3_y[k]);
        end
    end

    // Accumulator RAM: read in stage 2, write back in stage 3 except on the last spectrum.
    always_ff @(posedge clk) begin
        rd_q <= mem[s1_bin];
        if (s2_valid && !s2_last) mem[s2_bin] <= {wsum[3], wsum[2], wsum[1], wsum[0]};
    end

    // Pipeline stages 1..3; reset drops all in-flight samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_bin   <= '0;
            s1_shift <= '0;
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_bin   <= '0;
            s2_shift <= '0;
            s3_valid <= 1'b0;
            s3_bin   <= '0;
            for (int k = 0; k < 4; k++) begin
                s1_p[k] <= '0;
                s2_p[k] <= '0;
                s3_y[k] <= '0;
            end
        end else begin
            s1_valid <= accept;
            s1_first <= smp_first;
            s1_last  <= smp_last;
            s1_bin   <= smp_bin;
            s1_shift <= smp_shift;
            s2_valid <= s1_valid;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_bin   <= s1_bin;
            s2_shift <= s1_shift;
            s3_valid <= s2_valid && s2_last;
            s3_bin   <= s2_bin;
            for (int k = 0; k < 4; k++) begin
                s1_p[k] <= prod[k];
                s2_p[k] <= ACC_WIDTH'(s1_p[k]);
                s3_y[k] <= wsum[k] >>> sh_amt;
            end
        end
    end

    // Output register: data holds between vectors, flags only asserted with dout_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r11        <= '0;
            r22        <= '0;
            r12_re     <= '0;
            r12_im     <= '0;
            dout_bin   <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            dout_ovf   <= 1'b0;
        end else begin
            dout_valid <= s3_valid;
            if (s3_valid) begin
                r11       <= so[0][DOUT_WIDTH-1:0];
                r22       <= so[1][DOUT_WIDTH-1:0];
                r12_re    <= so[2][DOUT_WIDTH-1:0];
                r12_im    <= so[3][DOUT_WIDTH-1:0];
                dout_bin  <= s3_bin;
                dout_last <= (s3_bin == LAST_BIN);
                dout_ovf  <= so[0][DOUT_WIDTH] | so[1][DOUT_WIDTH] |
                             so[2][DOUT_WIDTH] | so[3][DOUT_WIDTH];
            end else begin
                dout_last <= 1'b0;
                dout_ovf  <= 1'b0;
            end
        end
    end

    assign sync_err = sync_err_q;

endmodule
